// File: rtl/saturation_pkg.sv
// saturation_pkg: mode encoding, pipeline latency and the shared unsigned clamp helper
package saturation_pkg;
   typedef enum logic [1:0] {MODE_BYPASS = 2'd0, MODE_SAT = 2'd1, MODE_GRAY = 2'd2} mode_e;
   localparam int LATENCY = 4;
   function automatic logic [31:0] clamp_u(input logic signed [63:0] v, input int w);
      logic signed [63:0] mx;
      mx = (64'sd1 <<< w) - 64'sd1;
      return (v < 0) ? 32'd0 : (v > mx) ? mx[31:0] : v[31:0];
   endfunction
endpackage

// File: rtl/saturation_lane.sv
// saturation_lane: one-pixel four-stage luma/saturation datapath; mode and gain travel with the pixel
module saturation_lane
   import saturation_pkg::*;
#(
   parameter int PW = 8,
   parameter int CW = 16,
   parameter int CF = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      mode_i,
   input  logic [CW-1:0]   sat_i,
   input  logic [CW-1:0]   c0_i,
   input  logic [CW-1:0]   c1_i,
   input  logic [CW-1:0]   c2_i,
   input  logic [3*PW-1:0] px_i,
   output logic [3*PW-1:0] px_o
);
   localparam int MW = PW + CW;
   localparam int SW = PW + CW + 2;
   localparam int PRW = PW + CW + 2;
   logic [2:0][CW-1:0] c;
   logic [2:0][MW-1:0] m_d, m_q;
   logic [2:0][PRW-1:0] p3_d, p3_q;
   logic [3*PW-1:0] x1_d, x1_q, x2_d, x2_q, x3_d, x3_q, o_d, o_q;
   logic [PW-1:0] y2_d, y2_q, y3_d, y3_q;
   logic [CW-1:0] sat1_d, sat1_q, sat2_d, sat2_q;
   logic [1:0] md1_d, md1_q, md2_d, md2_q, md3_d, md3_q;
   logic [SW-1:0] ysum;
   logic signed [PW:0] dv [3];
   logic signed [PRW-1:0] qv [3];
   logic [PW-1:0] sv [3];
   assign c = {c2_i, c1_i, c0_i};
   assign px_o = o_q;
   // S1 products, S2 luma, S3 chroma scaling, S4 recombine and mode select
   always_comb begin
      x1_d = px_i;
      md1_d = mode_i;
      sat1_d = sat_i;
      for (int k = 0; k < 3; k++) m_d[k] = MW'(c[k]) * MW'(px_i[k*PW +: PW]);
      ysum = SW'(m_q[0]) + SW'(m_q[1]) + SW'(m_q[2]);
      y2_d = PW'(clamp_u(64'(ysum >> CF), PW));
      x2_d = x1_q;
      md2_d = md1_q;
      sat2_d = sat1_q;
      for (int k = 0; k < 3; k++) begin
         dv[k] = $signed({1'b0, x2_q[k*PW +: PW]}) - $signed({1'b0, y2_q});
         p3_d[k] = PRW'(dv[k]) * PRW'($signed({1'b0, sat2_q}));
      end
      y3_d = y2_q;
      x3_d = x2_q;
      md3_d = md2_q;
      for (int k = 0; k < 3; k++) begin
         qv[k] = $signed(p3_q[k]) >>> CF;
         sv[k] = PW'(clamp_u($signed(64'(qv[k])) + $signed(64'(y3_q)), PW));
      end
      o_d = (md3_q == MODE_SAT) ? {sv[2], sv[1], sv[0]} : (md3_q == MODE_GRAY) ? {3{y3_q}} : x3_q;
   end
   // pipeline registers, all cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q <= '0;
         x1_q <= '0;
         md1_q <= '0;
         sat1_q <= '0;
         y2_q <= '0;
         x2_q <= '0;
         md2_q <= '0;
         sat2_q <= '0;
         p3_q <= '0;
         y3_q <= '0;
         x3_q <= '0;
         md3_q <= '0;
         o_q <= '0;
      end else begin
         m_q <= m_d;
         x1_q <= x1_d;
         md1_q <= md1_d;
         sat1_q <= sat1_d;
         y2_q <= y2_d;
         x2_q <= x2_d;
         md2_q <= md2_d;
         sat2_q <= sat2_d;
         p3_q <= p3_d;
         y3_q <= y3_d;
         x3_q <= x3_d;
         md3_q <= md3_d;
         o_q <= o_d;
      end
   end
endmodule

// File: rtl/saturation_ppc.sv
// saturation_ppc: multi-lane saturation filter with frame-boundary shadowed settings and aligned sidebands
module saturation_ppc
   import saturation_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int PPC = 1,
   parameter int COE_WIDTH = 16,
   parameter int COE_FRAC = 6,
   parameter int DBG_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     mode_i,
   input  logic [COE_WIDTH-1:0]           saturation_i,
   input  logic [COE_WIDTH-1:0]           ycoe0_i,
   input  logic [COE_WIDTH-1:0]           ycoe1_i,
   input  logic [COE_WIDTH-1:0]           ycoe2_i,
   input  logic [PPC*3*PIXEL_WIDTH-1:0]   di_i,
   input  logic                           de_i,
   input  logic                           hs_i,
   input  logic                           vs_i,
   input  logic [DBG_WIDTH-1:0]           dbg_i,
   output logic [PPC*3*PIXEL_WIDTH-1:0]   do_o,
   output logic                           de_o,
   output logic                           hs_o,
   output logic                           vs_o,
   output logic [DBG_WIDTH-1:0]           dbg_o
);
   localparam int SBW = DBG_WIDTH + 3;
   localparam int LW = 3 * PIXEL_WIDTH;
   logic vs_d, vs_q, ld;
   logic [1:0] mode_d, mode_q;
   logic [COE_WIDTH-1:0] sat_d, sat_q, c0_d, c0_q, c1_d, c1_q, c2_d, c2_q;
   logic [LATENCY-1:0][SBW-1:0] sb_d, sb_q;
   assign {de_o, hs_o, vs_o, dbg_o} = sb_q[LATENCY-1];
   // capture the settings only on a vsync rising edge; sidebands shift in step with the lanes
   always_comb begin
      vs_d = vs_i;
      ld = vs_i & ~vs_q;
      mode_d = ld ? mode_i : mode_q;
      sat_d = ld ? saturation_i : sat_q;
      c0_d = ld ? ycoe0_i : c0_q;
      c1_d = ld ? ycoe1_i : c1_q;
      c2_d = ld ? ycoe2_i : c2_q;
      sb_d = {sb_q[LATENCY-2:0], {de_i, hs_i, vs_i, dbg_i}};
   end
   // active settings, vsync history and sideband delay line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q <= 1'b0;
         mode_q <= MODE_BYPASS;
         sat_q <= COE_WIDTH'(1) << COE_FRAC;
         c0_q <= '0;
         c1_q <= '0;
         c2_q <= '0;
         sb_q <= '0;
      end else begin
         vs_q <= vs_d;
         mode_q <= mode_d;
         sat_q <= sat_d;
         c0_q <= c0_d;
         c1_q <= c1_d;
         c2_q <= c2_d;
         sb_q <= sb_d;
      end
   end
   for (genvar k = 0; k < PPC; k++) begin : g_lane
      saturation_lane #(.PW(PIXEL_WIDTH), .CW(COE_WIDTH), .CF(COE_FRAC)) u_lane (
         .clk(clk),
         .rst(rst),
         .mode_i(mode_q),
         .sat_i(sat_q),
         .c0_i(c0_q),
         .c1_i(c1_q),
         .c2_i(c2_q),
         .px_i(di_i[k*LW +: LW]),
         .px_o(do_o[k*LW +: LW])
      );
   end
endmodule

// File: tb/tb_saturation_ppc.sv
// tb_saturation_ppc: table vectors, hand sequences and a random soak against an arithmetic reference model
module tb_saturation_ppc;
   localparam int PW = 8, PPC = 4, CW = 16, CF = 6, DW = 16, XW = PPC * 3 * PW;
   logic clk = 0, rst = 0;
   logic [1:0] mode_i = 0;
   logic [CW-1:0] saturation_i = 64, ycoe0_i = 0, ycoe1_i = 0, ycoe2_i = 0;
   logic [XW-1:0] di_i = '0;
   logic de_i = 0, hs_i = 0, vs_i = 0;
   logic [DW-1:0] dbg_i = '0;
   logic [XW-1:0] do_o;
   logic de_o, hs_o, vs_o;
   logic [DW-1:0] dbg_o;
   always #5 clk = ~clk;
   saturation_ppc #(.PIXEL_WIDTH(PW), .PPC(PPC), .COE_WIDTH(CW), .COE_FRAC(CF), .DBG_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .mode_i(mode_i), .saturation_i(saturation_i),
      .ycoe0_i(ycoe0_i), .ycoe1_i(ycoe1_i), .ycoe2_i(ycoe2_i),
      .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .dbg_i(dbg_i),
      .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .dbg_o(dbg_o)
   );
   typedef struct {logic [XW-1:0] d; logic de, hs, vs; logic [DW-1:0] dbg;} exp_t;
   typedef struct {int m; int sat; logic [23:0] px; logic [23:0] ex;} vec_t;
   exp_t pend[$];
   vec_t tbl[9];
   int n_cmp = 0, n_bad = 0;
   int m_mode, m_sat, m_c0, m_c1, m_c2;
   logic m_vs;
   logic [23:0] pe;
   // luma and gain from the written rules, floor division for the signed shift
   function automatic logic [23:0] ref_px(int m, int sat, int c0, int c1, int c2, logic [23:0] px);
      longint x[3], y, p, q, s;
      logic [23:0] r;
      for (int i = 0; i < 3; i++) x[i] = longint'(px[i*8 +: 8]);
      y = (c0 * x[0] + c1 * x[1] + c2 * x[2]) / 64;
      if (y > 255) y = 255;
      r = px;
      for (int i = 0; i < 3; i++) begin
         p = (x[i] - y) * sat;
         q = (p >= 0) ? p / 64 : -((-p + 63) / 64);
         s = y + q;
         if (s < 0) s = 0;
         if (s > 255) s = 255;
         if (m == 1) r[i*8 +: 8] = s[7:0];
         else if (m == 2) r[i*8 +: 8] = y[7:0];
      end
      return r;
   endfunction
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] ex);
      n_cmp++;
      if (act !== ex) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, ex);
      end
   endtask
   task automatic cycle();
      exp_t e;
      for (int l = 0; l < PPC; l++) e.d[l*24 +: 24] = ref_px(m_mode, m_sat, m_c0, m_c1, m_c2, di_i[l*24 +: 24]);
      e.de = de_i;
      e.hs = hs_i;
      e.vs = vs_i;
      e.dbg = dbg_i;
      pend.push_back(e);
      if (vs_i && !m_vs) begin
         m_mode = int'(mode_i);
         m_sat = int'(saturation_i);
         m_c0 = int'(ycoe0_i);
         m_c1 = int'(ycoe1_i);
         m_c2 = int'(ycoe2_i);
      end
      m_vs = vs_i;
      @(posedge clk);
      #1;
      e = pend.pop_front();
      chk("stream", {do_o, de_o, hs_o, vs_o, dbg_o}, {e.d, e.de, e.hs, e.vs, e.dbg});
   endtask
   task automatic reset_dut();
      exp_t z;
      rst = 1;
      vs_i = 0;
      de_i = 0;
      #1;
      chk("reset_now", {do_o, de_o, hs_o, vs_o, dbg_o}, '0);
      @(posedge clk);
      #1;
      chk("reset_hold", {do_o, de_o, hs_o, vs_o, dbg_o}, '0);
      rst = 0;
      z.d = '0;
      z.de = 0;
      z.hs = 0;
      z.vs = 0;
      z.dbg = '0;
      pend.delete();
      repeat (3) pend.push_back(z);
      m_mode = 0;
      m_sat = 64;
      m_c0 = 0;
      m_c1 = 0;
      m_c2 = 0;
      m_vs = 0;
   endtask
   task automatic load(input int m, input int sat);
      mode_i = 2'(m);
      saturation_i = CW'(sat);
      ycoe0_i = 19;
      ycoe1_i = 37;
      ycoe2_i = 9;
      de_i = 0;
      vs_i = 1;
      cycle();
      vs_i = 0;
      cycle();
   endtask
   task automatic rand_px();
      for (int l = 0; l < PPC; l++) di_i[l*24 +: 24] = 24'($urandom);
   endtask
   initial begin
      tbl[0] = '{1, 64, {8'd100, 8'd100, 8'd100}, {8'd100, 8'd100, 8'd100}};
      tbl[1] = '{1, 128, {8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd255}};
      tbl[2] = '{2, 64, {8'd10, 8'd50, 8'd200}, {8'd89, 8'd89, 8'd89}};
      tbl[3] = '{1, 0, {8'd10, 8'd50, 8'd200}, {8'd89, 8'd89, 8'd89}};
      tbl[4] = '{0, 64, {8'd56, 8'd34, 8'd12}, {8'd56, 8'd34, 8'd12}};
      tbl[5] = '{2, 64, {8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255}};
      tbl[6] = '{3, 128, {8'd1, 8'd2, 8'd3}, {8'd1, 8'd2, 8'd3}};
      tbl[7] = '{1, 96, {8'd200, 8'd100, 8'd10}, {8'd255, 8'd106, 8'd0}};
      tbl[8] = '{1, 32, {8'd100, 8'd100, 8'd100}, {8'd100, 8'd100, 8'd100}};
      #1;
      reset_dut();
      for (int i = 0; i < 9; i++) begin
         load(tbl[i].m, tbl[i].sat);
         di_i = {PPC{tbl[i].px}};
         de_i = 1;
         hs_i = 1;
         dbg_i = DW'(i + 1);
         cycle();
         de_i = 0;
         hs_i = 0;
         di_i = '0;
         repeat (3) cycle();
         chk($sformatf("tbl%0d_do", i), 128'(do_o), 128'({PPC{tbl[i].ex}}));
         chk($sformatf("tbl%0d_de", i), 128'(de_o), 128'(1));
      end
      load(0, 64);
      mode_i = 2;
      de_i = 1;
      repeat (4) begin
         rand_px();
         cycle();
      end
      pe = {8'd10, 8'd50, 8'd200};
      di_i = {PPC{pe}};
      vs_i = 1;
      cycle();
      mode_i = 1;
      saturation_i = 128;
      cycle();
      cycle();
      vs_i = 0;
      cycle();
      chk("shadow_edge", 128'(do_o), 128'({PPC{pe}}));
      cycle();
      chk("shadow_next", 128'(do_o), 128'({PPC{24'h595959}}));
      cycle();
      chk("shadow_hold", 128'(do_o), 128'({PPC{24'h595959}}));
      de_i = 1;
      repeat (5) begin
         rand_px();
         dbg_i = DW'($urandom);
         hs_i = 1'($urandom);
         cycle();
      end
      reset_dut();
      mode_i = 2;
      di_i = {PPC{pe}};
      de_i = 1;
      cycle();
      de_i = 0;
      repeat (3) cycle();
      chk("post_reset_bypass", 128'(do_o), 128'({PPC{pe}}));
      load(1, 64);
      for (int t = 0; t < 2500; t++) begin
         rand_px();
         de_i = ($urandom_range(0, 7) != 0);
         hs_i = 1'($urandom);
         dbg_i = DW'($urandom);
         vs_i = (t % 97) < 3;
         mode_i = 2'($urandom_range(0, 3));
         saturation_i = CW'($urandom_range(0, 191));
         cycle();
      end
      de_i = 0;
      vs_i = 0;
      repeat (4) cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
